// File: rtl/hdmi_tmds_pkg.sv
// Shared definitions for the TMDS encoder array: mode encodings, fixed
// symbol constants and small combinational helpers.
package hdmi_tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL   = 2'd0,
        MODE_VIDEO  = 2'd1,
        MODE_VGUARD = 2'd2,
        MODE_TERC4  = 2'd3
    } mode_t;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic [9:0] GUARD_A = 10'b1011001100;
    localparam logic [9:0] GUARD_B = 10'b0100110011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            2'b11:   s = CTRL_11;
            default: s = CTRL_00;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] d);
        logic [9:0] s;
        case (d)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000110;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            4'hF:    s = 10'b1011000011;
            default: s = 10'b1010011100;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hdmi_tmds_encoder_array_channel.sv
// One TMDS channel: stage 1 transition minimisation, stage 2 symbol select
// and running-disparity update. Mode/valid for stage 2 come from the top.
module tmds_channel_enc
    import hdmi_tmds_pkg::*;
#(
    parameter int CH_IDX = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_i,
    input  logic [1:0] ctrl_i,
    input  logic [3:0] terc4_i,
    input  mode_t      mode_s1,
    input  logic       valid_s1,
    output logic [9:0] sym_o
);

    logic [3:0]        n1_d_s;
    logic [8:0]        q_m_s;
    logic [8:0]        q_m_r;
    logic [3:0]        n1_r;
    logic [1:0]        ctrl_r;
    logic [3:0]        terc4_r;
    logic signed [4:0] cnt_r;
    logic signed [4:0] cnt_nxt_s;
    logic signed [5:0] cnt_ext_s;
    logic signed [5:0] diff_s;
    logic signed [5:0] upd_s;
    logic [9:0]        sym_r;
    logic [9:0]        sym_nxt_s;

    // Transition-minimised word from the raw video byte
    always_comb begin
        n1_d_s   = popcount8(data_i);
        q_m_s    = 9'd0;
        q_m_s[0] = data_i[0];
        if ((n1_d_s > 4'd4) || ((n1_d_s == 4'd4) && (data_i[0] == 1'b0))) begin
            for (int i = 1; i < 8; i++) begin
                q_m_s[i] = ~(q_m_s[i-1] ^ data_i[i]);
            end
            q_m_s[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) begin
                q_m_s[i] = q_m_s[i-1] ^ data_i[i];
            end
            q_m_s[8] = 1'b1;
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_m_r   <= 9'd0;
            n1_r    <= 4'd0;
            ctrl_r  <= 2'd0;
            terc4_r <= 4'd0;
        end else begin
            q_m_r   <= q_m_s;
            n1_r    <= popcount8(q_m_s[7:0]);
            ctrl_r  <= ctrl_i;
            terc4_r <= terc4_i;
        end
    end

    // Symbol selection; diff_s is n1 - n0 of q_m[7:0], i.e. 2*n1 - 8
    always_comb begin
        diff_s    = $signed({1'b0, n1_r, 1'b0}) - 6'sd8;
        cnt_ext_s = {cnt_r[4], cnt_r};
        upd_s     = cnt_ext_s;
        sym_nxt_s = CTRL_00;
        cnt_nxt_s = 5'sd0;
        case (mode_s1)
            MODE_VIDEO: begin
                if ((cnt_r == 5'sd0) || (diff_s == 6'sd0)) begin
                    sym_nxt_s = {~q_m_r[8], q_m_r[8], q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0]};
                    upd_s     = q_m_r[8] ? (cnt_ext_s + diff_s) : (cnt_ext_s - diff_s);
                end else if ((!cnt_r[4] && (diff_s > 6'sd0)) || (cnt_r[4] && (diff_s < 6'sd0))) begin
                    sym_nxt_s = {1'b1, q_m_r[8], ~q_m_r[7:0]};
                    upd_s     = cnt_ext_s + (q_m_r[8] ? 6'sd2 : 6'sd0) - diff_s;
                end else begin
                    sym_nxt_s = {1'b0, q_m_r[8], q_m_r[7:0]};
                    upd_s     = cnt_ext_s - (q_m_r[8] ? 6'sd0 : 6'sd2) + diff_s;
                end
                if (valid_s1) begin
                    cnt_nxt_s = upd_s[4:0];
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            MODE_CTRL: begin
                sym_nxt_s = ctrl_code(ctrl_r);
            end
            MODE_VGUARD: begin
                sym_nxt_s = ((CH_IDX % 3) == 1) ? GUARD_B : GUARD_A;
            end
            MODE_TERC4: begin
                sym_nxt_s = terc4_code(terc4_r);
            end
            default: begin
                sym_nxt_s = CTRL_00;
            end
        endcase
    end

    // Stage 2 registers: output symbol and disparity counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_r <= CTRL_00;
            cnt_r <= 5'sd0;
        end else begin
            sym_r <= sym_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    assign sym_o = sym_r;

endmodule

// File: rtl/hdmi_tmds_encoder_array.sv
// N-channel TMDS encoder: per-channel encoders plus the shared mode/valid
// pipeline and an optional output register stage.
module hdmi_tmds_encoder_array
    import hdmi_tmds_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int PIPE_OUT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_i,
    input  logic [1:0]             mode_i,
    input  logic [NUM_CH*8-1:0]    data_i,
    input  logic [NUM_CH*2-1:0]    ctrl_i,
    input  logic [NUM_CH*4-1:0]    terc4_i,
    output logic [NUM_CH*10-1:0]   tmds_o,
    output logic                   valid_o
);

    mode_t                mode_s1_r;
    logic                 valid_s1_r;
    logic                 valid_s2_r;
    logic [NUM_CH*10-1:0] sym_s2_s;

    // Shared mode/valid pipeline feeding every channel's stage 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1_r  <= MODE_CTRL;
            valid_s1_r <= 1'b0;
            valid_s2_r <= 1'b0;
        end else begin
            mode_s1_r  <= mode_t'(mode_i);
            valid_s1_r <= valid_i;
            valid_s2_r <= valid_s1_r;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tmds_channel_enc #(.CH_IDX(k)) u_enc (
            .clk      (clk),
            .rst_n    (rst_n),
            .data_i   (data_i[8*k +: 8]),
            .ctrl_i   (ctrl_i[2*k +: 2]),
            .terc4_i  (terc4_i[4*k +: 4]),
            .mode_s1  (mode_s1_r),
            .valid_s1 (valid_s1_r),
            .sym_o    (sym_s2_s[10*k +: 10])
        );
    end

    if (PIPE_OUT != 0) begin : g_pipe
        logic [NUM_CH*10-1:0] tmds_r;
        logic                 valid_s3_r;

        // Extra output stage for timing into the serialiser
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tmds_r     <= {NUM_CH{CTRL_00}};
                valid_s3_r <= 1'b0;
            end else begin
                tmds_r     <= sym_s2_s;
                valid_s3_r <= valid_s2_r;
            end
        end

        assign tmds_o  = tmds_r;
        assign valid_o = valid_s3_r;
    end else begin : g_nopipe
        assign tmds_o  = sym_s2_s;
        assign valid_o = valid_s2_r;
    end

endmodule

// File: tb/tb_hdmi_tmds_encoder_array.sv
// Scoreboard bench for hdmi_tmds_encoder_array (NUM_CH=3, PIPE_OUT=1):
// directed mode vectors, a modelled video stream and a mid-stream reset.
module tb_hdmi_tmds_encoder_array;

    localparam int NCH = 3;
    localparam int W   = NCH * 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid_i = 1'b0;
    logic [1:0]       mode_i = 2'd0;
    logic [NCH*8-1:0] data_i = '0;
    logic [NCH*2-1:0] ctrl_i = '0;
    logic [NCH*4-1:0] terc4_i = '0;
    logic [W-1:0]     tmds_o;
    logic             valid_o;

    logic [W-1:0] sb[$];
    int checks = 0;
    int passes = 0;
    int mcnt[NCH];

    always #5 clk = ~clk;

    hdmi_tmds_encoder_array #(.NUM_CH(NCH), .PIPE_OUT(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .mode_i  (mode_i),
        .data_i  (data_i),
        .ctrl_i  (ctrl_i),
        .terc4_i (terc4_i),
        .tmds_o  (tmds_o),
        .valid_o (valid_o)
    );

    function automatic logic [W-1:0] rep(input logic [9:0] s);
        return {NCH{s}};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference video encoder written from the DVI equations with integer counts
    task automatic ref_video(input logic [7:0] d, input int cin, output logic [9:0] sym, output int cout);
        int nd, ones, zeros;
        logic [8:0] qm;
        nd = 0;
        for (int i = 0; i < 8; i++) nd += d[i];
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            if (nd > 4 || (nd == 4 && d[0] == 1'b0)) qm[i] = ~(qm[i-1] ^ d[i]);
            else qm[i] = qm[i-1] ^ d[i];
        end
        qm[8] = (nd > 4 || (nd == 4 && d[0] == 1'b0)) ? 1'b0 : 1'b1;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += qm[i];
        zeros = 8 - ones;
        cout = cin;
        if (cin == 0 || ones == zeros) begin
            if (qm[8]) begin
                sym = {2'b01, qm[7:0]};
                cout = cin + ones - zeros;
            end else begin
                sym = {2'b10, ~qm[7:0]};
                cout = cin + zeros - ones;
            end
        end else if ((cin > 0 && ones > zeros) || (cin < 0 && zeros > ones)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            cout = cin + 2 * int'(qm[8]) + zeros - ones;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            cout = cin - 2 * (1 - int'(qm[8])) + ones - zeros;
        end
    endtask

    task automatic beat(input logic [1:0] m, input logic v, input logic [NCH*8-1:0] d,
                        input logic [NCH*2-1:0] c, input logic [NCH*4-1:0] t,
                        input logic push, input logic [W-1:0] exp);
        mode_i  = m;
        valid_i = v;
        data_i  = d;
        ctrl_i  = c;
        terc4_i = t;
        if (push) sb.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic vbeat(input logic [NCH*8-1:0] d, input logic v);
        logic [W-1:0] exp;
        logic [9:0]   s;
        int           nc;
        for (int k = 0; k < NCH; k++) begin
            ref_video(d[8*k +: 8], mcnt[k], s, nc);
            exp[10*k +: 10] = s;
            if (v) mcnt[k] = nc;
        end
        beat(2'd1, v, d, '0, '0, v, exp);
    endtask

    // Monitor: pop one expectation per valid output beat
    always @(negedge clk) begin
        if (rst_n && valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid: got %h expected no output", tmds_o);
            end else begin
                check("symbol", tmds_o, sb.pop_front());
            end
        end
    end

    initial begin
        logic [NCH*8-1:0] rd;
        for (int k = 0; k < NCH; k++) mcnt[k] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_tmds", tmds_o, rep(10'h354));
        check("reset_valid", {{(W-1){1'b0}}, valid_o}, '0);
        rst_n = 1'b1;

        repeat (3) beat(2'd0, 1'b1, '0, '0, '0, 1'b1, rep(10'h354));

        beat(2'd1, 1'b1, '0, '0, '0, 1'b1, rep(10'h100));
        beat(2'd1, 1'b1, '0, '0, '0, 1'b1, rep(10'h3FF));
        beat(2'd1, 1'b1, '0, '0, '0, 1'b1, rep(10'h100));
        beat(2'd1, 1'b1, '0, '0, '0, 1'b1, rep(10'h3FF));

        beat(2'd0, 1'b1, '0, {NCH{2'b00}}, '0, 1'b1, rep(10'h354));
        beat(2'd0, 1'b1, '0, {NCH{2'b01}}, '0, 1'b1, rep(10'h0AB));
        beat(2'd0, 1'b1, '0, {NCH{2'b10}}, '0, 1'b1, rep(10'h154));
        beat(2'd0, 1'b1, '0, {NCH{2'b11}}, '0, 1'b1, rep(10'h2AB));
        beat(2'd1, 1'b1, '0, '0, '0, 1'b1, rep(10'h100));

        beat(2'd0, 1'b1, '0, '0, '0, 1'b1, rep(10'h354));
        beat(2'd1, 1'b1, {NCH{8'hFF}}, '0, '0, 1'b1, rep(10'h200));

        beat(2'd2, 1'b1, '0, '0, '0, 1'b1, {10'h2CC, 10'h133, 10'h2CC});
        beat(2'd3, 1'b1, '0, '0, '0, 1'b1, rep(10'h29C));
        beat(2'd3, 1'b1, '0, '0, {4'hF, 4'h8, 4'h1}, 1'b1, {10'h2C3, 10'h2CC, 10'h263});

        // Disparity must be held across an invalid video beat
        beat(2'd0, 1'b1, '0, '0, '0, 1'b1, rep(10'h354));
        beat(2'd1, 1'b1, '0, '0, '0, 1'b1, rep(10'h100));
        beat(2'd1, 1'b0, '0, '0, '0, 1'b0, '0);
        beat(2'd1, 1'b1, '0, '0, '0, 1'b1, rep(10'h3FF));

        beat(2'd0, 1'b1, '0, '0, '0, 1'b1, rep(10'h354));
        for (int k = 0; k < NCH; k++) mcnt[k] = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                rst_n = 1'b0;
                valid_i = 1'b0;
                #1;
                check("midreset_tmds", tmds_o, rep(10'h354));
                check("midreset_valid", {{(W-1){1'b0}}, valid_o}, '0);
                sb.delete();
                for (int k = 0; k < NCH; k++) mcnt[k] = 0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            for (int k = 0; k < NCH; k++) rd[8*k +: 8] = 8'($urandom);
            vbeat(rd, ($urandom_range(0, 4) != 0));
        end

        beat(2'd0, 1'b0, '0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
